// File: rtl/fetch_unit.sv
// RV32 instruction fetch stage: owns the PC, issues in-order word reads and
// buffers returned instructions for the decoder; redirects flush and drop in-flight reads.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        CLK,
  input  logic        RST,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef logic [CW-1:0] cnt_t;
  typedef logic [PW-1:0] ptr_t;

  localparam logic [CW:0] DEPTH_W   = (CW+1)'(DEPTH);
  localparam ptr_t        PTR_LAST  = ptr_t'(DEPTH - 1);

  logic [31:0] pc_q, pc_d;
  cnt_t        count_q, count_d;
  cnt_t        outst_q, outst_d;
  cnt_t        drop_q, drop_d;
  ptr_t        head_q, head_d;
  ptr_t        tail_q, tail_d;
  logic        run_q;

  logic [31:0] q_inst_q [DEPTH];
  logic [31:0] q_pc_q   [DEPTH];

  logic        credit_ok;
  logic [CW:0] in_use;
  logic        accept;
  logic        resp;
  logic        push;
  logic        pop;
  logic [31:0] resp_pc;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == PTR_LAST) ? '0 : ptr_t'(p + ptr_t'(1));
  endfunction

  // Credits cover both queued entries and reads still in flight, so a
  // returning response always has a free slot.
  assign in_use    = {1'b0, count_q} + {1'b0, outst_q};
  assign credit_ok = (in_use < DEPTH_W);

  // run_q holds requests off until the cycle after reset is released.
  assign imem_req  = RST && run_q && !redirect && credit_ok;
  assign imem_addr = pc_q;

  assign accept = imem_req && imem_ready;
  assign resp   = imem_rvalid && (outst_q != '0);
  assign push   = resp && (drop_q == '0) && !redirect;
  assign pop    = (count_q != '0) && inst_ready && !redirect;

  // With no drops pending, every outstanding read is part of one contiguous
  // run ending just below pc, so the oldest sits outst words back.
  assign resp_pc = pc_q - {{(30-CW){1'b0}}, outst_q, 2'b00};

  always_comb begin
    pc_d    = pc_q;
    count_d = count_q;
    outst_d = outst_q;
    drop_d  = drop_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (redirect) begin
      pc_d    = {redirect_pc[31:2], 2'b00};
      count_d = '0;
      outst_d = outst_q - cnt_t'(resp);
      drop_d  = outst_q - cnt_t'(resp);
      tail_d  = head_q;
    end else begin
      if (accept) begin
        pc_d = pc_q + 32'd4;
      end
      outst_d = outst_q + cnt_t'(accept) - cnt_t'(resp);
      drop_d  = drop_q - cnt_t'(resp && (drop_q != '0));
      count_d = count_q + cnt_t'(push) - cnt_t'(pop);
      if (pop) begin
        head_d = ptr_inc(head_q);
      end
      if (push) begin
        tail_d = ptr_inc(tail_q);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      pc_q    <= RESET_PC;
      count_q <= '0;
      outst_q <= '0;
      drop_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      run_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        q_inst_q[i] <= '0;
        q_pc_q[i]   <= '0;
      end
    end else begin
      pc_q    <= pc_d;
      count_q <= count_d;
      outst_q <= outst_d;
      drop_q  <= drop_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      run_q   <= 1'b1;
      if (push) begin
        q_inst_q[tail_q] <= imem_rdata;
        q_pc_q[tail_q]   <= resp_pc;
      end
    end
  end

  assign inst_valid = (count_q != '0);
  assign inst       = q_inst_q[head_q];
  assign inst_pc    = q_pc_q[head_q];

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: a latency-programmable memory feeds the DUT
// and a queue-based model of the fetch rules predicts every visible output.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  logic        CLK = 1'b0;
  logic        RST;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready)
  );

  always #5 CLK = ~CLK;

  typedef struct { logic [31:0] addr; int due; } pend_t;
  typedef struct { logic [31:0] addr; bit drop; } oq_t;
  typedef struct { logic [31:0] inst; logic [31:0] pc; } iq_t;

  pend_t pend[$];
  oq_t   oq[$];
  iq_t   iq[$];
  logic [31:0] mpc = RESET_PC;
  bit    mrun = 1'b0;
  int    cyc = 0;
  int    last_due = 0;

  int n_chk = 0;
  int n_pass = 0;

  bit          s_valid;
  bit          s_req;
  logic [31:0] s_pc;
  logic [31:0] s_addr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    else
      n_pass++;
  endtask

  task automatic step(input bit rst_v, input bit redir_v, input logic [31:0] rpc_v,
                      input bit iready_v, input bit mready_v, input bit rv_allow,
                      input bit stray, input int lat);
    bit          rv;
    logic [31:0] rd;
    bit          exp_req;
    bit          dut_acc;
    logic [31:0] acc_addr;
    bit          do_pop;
    int          due;
    oq_t         e;
    @(negedge CLK);
    rv = 1'b0;
    rd = $urandom;
    if (rv_allow && pend.size() > 0 && pend[0].due <= cyc) begin
      rv = 1'b1;
      rd = pend[0].addr ^ 32'hA5A5_0000;
    end else if (stray && pend.size() == 0) begin
      rv = 1'b1;
    end
    RST = rst_v; redirect = redir_v; redirect_pc = rpc_v; inst_ready = iready_v;
    imem_ready = mready_v; imem_rvalid = rv; imem_rdata = rd;
    #1;
    exp_req = rst_v && mrun && !redir_v && (iq.size() + oq.size() < DEPTH);
    chk("imem_req", imem_req, exp_req);
    chk("imem_addr", imem_addr, mpc);
    chk("inst_valid", inst_valid, iq.size() > 0);
    if (iq.size() > 0) begin
      chk("inst", inst, iq[0].inst);
      chk("inst_pc", inst_pc, iq[0].pc);
    end
    chk("outst_max", pend.size() <= DEPTH, 1);
    s_valid = inst_valid; s_req = imem_req; s_pc = inst_pc; s_addr = imem_addr;
    dut_acc  = imem_req && mready_v;
    acc_addr = imem_addr;
    @(posedge CLK);
    if (!rst_v) begin
      pend.delete();
      last_due = 0;
    end else begin
      if (rv && pend.size() > 0) void'(pend.pop_front());
      if (dut_acc) begin
        due = cyc + lat;
        if (due < last_due) due = last_due;
        last_due = due;
        pend.push_back('{acc_addr, due});
      end
    end
    cyc++;
    if (!rst_v) begin
      iq.delete(); oq.delete(); mpc = RESET_PC; mrun = 1'b0;
    end else begin
      mrun = 1'b1;
      if (redir_v) begin
        if (rv && oq.size() > 0) void'(oq.pop_front());
        foreach (oq[i]) oq[i].drop = 1'b1;
        iq.delete();
        mpc = rpc_v & ~32'h3;
      end else begin
        do_pop = (iq.size() > 0) && iready_v;
        if (do_pop) void'(iq.pop_front());
        if (rv && oq.size() > 0) begin
          e = oq.pop_front();
          if (!e.drop) iq.push_back('{rd, e.addr});
        end
        if (exp_req && mready_v) begin
          oq.push_back('{mpc, 1'b0});
          mpc = mpc + 32'd4;
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    bit          seen;
    int          tries;
    logic [31:0] pcs[$];
    logic [31:0] exp_pc;
    RST = 1'b0; redirect = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;

    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 1, 1, 0, 1);
    #1;
    chk("rst_inst", inst, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_addr", imem_addr, RESET_PC);

    // Single-cycle memory, decoder always ready.
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1, 0, 0, 1, 1, 1, 0, 1);
      if (s_valid) pcs.push_back(s_pc);
      if (!seen && s_valid) begin
        chk("first_valid_lat", i, 3);
        seen = 1'b1;
      end
    end
    chk("first_valid_seen", seen, 1);
    for (int i = 0; i < 4; i++) begin
      exp_pc = 32'(i * 4);
      chk("seq_pc", (pcs.size() > i) ? pcs[i] : 32'hFFFF_FFFF, exp_pc);
    end

    // Decoder stall: queue fills and requests stop.
    for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 1, 1, 0, 1);
    chk("stall_req", s_req, 0);
    chk("stall_valid", s_valid, 1);
    for (int i = 0; i < 10; i++) step(1, 0, 0, 1, 1, 1, 0, 1);

    // Three-cycle memory with toggling imem_ready.
    for (int i = 0; i < 40; i++) step(1, 0, 0, 1, 1'($urandom), 1, 0, 3);

    // Redirect with two reads in flight.
    tries = 0;
    while (oq.size() != 2 && tries < 20) begin
      step(1, 0, 0, 1, 1, 1, 0, 3);
      tries++;
    end
    chk("redir_setup", oq.size(), 2);
    step(1, 1, 32'h0000_0103, 1, 1, 1, 0, 3);
    step(1, 0, 0, 1, 1, 1, 0, 3);
    chk("redir_addr", s_addr, 32'h0000_0100);
    tries = 0;
    while (!s_valid && tries < 20) begin
      step(1, 0, 0, 1, 1, 1, 0, 3);
      tries++;
    end
    chk("redir_first_pc", s_pc, 32'h0000_0100);

    // Redirect coinciding with a response and a pop.
    tries = 0;
    while (!(iq.size() > 0 && pend.size() > 0 && pend[0].due <= cyc) && tries < 30) begin
      step(1, 0, 0, 1, 1'($urandom), 1, 0, 1);
      tries++;
    end
    chk("redir_rv_setup", (iq.size() > 0 && pend.size() > 0), 1);
    step(1, 1, 32'h0000_2000, 1, 1, 1, 0, 1);
    #1;
    chk("redir_rv_flush", inst_valid, 0);
    for (int i = 0; i < 10; i++) step(1, 0, 0, 1, 1, 1, 0, 1);

    // Reset with reads outstanding, then stray responses.
    tries = 0;
    while (oq.size() == 0 && tries < 20) begin
      step(1, 0, 0, 1, 1, 1, 0, 3);
      tries++;
    end
    chk("mid_rst_setup", oq.size() > 0, 1);
    step(0, 0, 0, 1, 1, 1, 0, 3);
    #1;
    chk("mid_rst_valid", inst_valid, 0);
    chk("mid_rst_addr", imem_addr, RESET_PC);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 1, 0, 1, 1, 1);
    for (int i = 0; i < 10; i++) step(1, 0, 0, 1, 1, 1, 1, 1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 299) != 0),
           ($urandom_range(0, 11) == 0),
           $urandom,
           1'($urandom),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 7) == 0),
           $urandom_range(1, 4));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
